// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for rr_arb_mux and later muxes/arbiters.
// Index-width and wrap helpers.
package rr_arb_mux_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int wrap_idx(input int a, input int n);
        return (a >= n) ? a - n : a;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Rotating priority encoder: first requester at or after ptr wins.
// Emits a one-hot grant, its encoded index and an any-request flag.
module rr_grant
    import rr_arb_mux_pkg::*;
#(
    parameter int NCH = 4,
    localparam int CW = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  gidx,
    output logic           any
);

    int j;

    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NCH; k++) begin
            j = wrap_idx(int'(ptr) + k, NCH);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                gidx     = CW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with a one-entry output register.
// Define RR_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-first priority.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int CW   = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_ch,
    input  logic                 out_ready
);

    logic             load;
    logic             xfer;
    logic             any;
    logic [NCH-1:0]   grant;
    logic [CW-1:0]    gidx;
    logic [CW-1:0]    ptr;
    logic [WIDTH-1:0] win_data;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;

    rr_grant #(.NCH(NCH)) u_grant (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    assign load     = !out_valid_q || out_ready;
    assign xfer     = any && load && !rst;
    assign in_ready = rst ? '0 : (grant & {NCH{load}});
    assign win_data = in_data[int'(gidx)*WIDTH +: WIDTH];

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [CW-1:0] ptr_q, ptr_d;

    // Pointer moves past the winner only on an accepted beat.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gidx == CW'(NCH - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_ch_d    = gidx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: vector table, scoreboard and corner sequences.
// Expectations follow the RR_ARB_MUX_FIXED_PRIO_EN setting of the build.
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  rdy3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  och3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(8), .NCH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .NCH(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_ch(och3),
        .out_ready(1'b1)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Scoreboard model, evaluated mid-cycle
    typedef struct { int ch; logic [7:0] d; } beat_t;
    beat_t q[$];
    beat_t b;
    logic  ov_m = 1'b0;
    int    ptr_m = 0;
    int    g;
    logic  load_m;
    logic [3:0] exp_rdy;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            ov_m  = 1'b0;
            ptr_m = 0;
        end else begin
            load_m  = !ov_m || out_ready;
            g       = pick(in_valid, ptr_m);
            exp_rdy = '0;
            if (load_m && g >= 0) exp_rdy[g] = 1'b1;
            chk("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("sb_out_valid", 32'(out_valid), 32'(ov_m));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got beat ch %0d want none", out_ch);
                end else begin
                    b = q.pop_front();
                    chk("sb_out_ch", 32'(out_ch), b.ch);
                    chk("sb_out_data", 32'(out_data), 32'(b.d));
                end
            end
            if (exp_rdy != 0) begin
                b.ch = g;
                b.d  = in_data[g*8 +: 8];
                q.push_back(b);
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
                ptr_m = (g == 3) ? 0 : g + 1;
`endif
                ov_m = 1'b1;
            end else if (out_ready) begin
                ov_m = 1'b0;
            end
        end
    end

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        r;
        logic        ev;
        int          ech;
        logic [7:0]  edat;
    } vec_t;

    vec_t tbl[8];

    task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        tbl[0] = '{4'b0100, 32'h44A53311, 1'b1, 1'b1, 2, 8'hA5};
        tbl[1] = '{4'b1111, 32'h04030201, 1'b1, 1'b1, 0, 8'h01};
        tbl[2] = '{4'b1111, 32'h14131211, 1'b1, 1'b1, 0, 8'h11};
        tbl[3] = '{4'b1110, 32'h24232221, 1'b1, 1'b1, 1, 8'h22};
        tbl[4] = '{4'b1111, 32'h34333231, 1'b1, 1'b1, 0, 8'h31};
        tbl[5] = '{4'b1000, 32'h44434241, 1'b1, 1'b1, 3, 8'h44};
        tbl[6] = '{4'b0000, 32'h0,        1'b1, 1'b0, 3, 8'h44};
        tbl[7] = '{4'b0000, 32'h0,        1'b0, 1'b0, 3, 8'h44};
`else
        tbl[0] = '{4'b0100, 32'h44A53311, 1'b1, 1'b1, 2, 8'hA5};
        tbl[1] = '{4'b1111, 32'h04030201, 1'b1, 1'b1, 3, 8'h04};
        tbl[2] = '{4'b1111, 32'h14131211, 1'b1, 1'b1, 0, 8'h11};
        tbl[3] = '{4'b1111, 32'h24232221, 1'b1, 1'b1, 1, 8'h22};
        tbl[4] = '{4'b1111, 32'h34333231, 1'b1, 1'b1, 2, 8'h33};
        tbl[5] = '{4'b1111, 32'h44434241, 1'b1, 1'b1, 3, 8'h44};
        tbl[6] = '{4'b0000, 32'h0,        1'b1, 1'b0, 3, 8'h44};
        tbl[7] = '{4'b0000, 32'h0,        1'b0, 1'b0, 3, 8'h44};
`endif
        rst = 1'b1;
        in_valid = 4'b1111;
        in_data = 32'hDDCCBBAA;
        out_ready = 1'b1;
        v3 = '0;
        d3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_ch", i), 32'(out_ch), tbl[i].ech);
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].edat));
        end

        // Reset while a beat is stalled
        apply(4'b1111, 32'h58575655, 1'b0);
        apply(4'b1111, 32'h58575655, 1'b0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_ch", 32'(out_ch), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Backpressure from reset
        apply(4'b1111, 32'h64636261, 1'b1);
        chk("bp_first_ch", 32'(out_ch), 32'd0);
        for (int i = 0; i < 5; i++) begin
            apply(4'b1111, 32'h74737271 + 32'(i), 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_ch", 32'(out_ch), 32'd0);
            chk("bp_hold_data", 32'(out_data), 32'h61);
        end
        apply(4'b1111, 32'h84838281, 1'b1);
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        chk("bp_next_ch", 32'(out_ch), 32'd0);
`else
        chk("bp_next_ch", 32'(out_ch), 32'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            apply(4'b1111, 32'h94939291 + 32'(i * 16), 1'b1);
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
            chk("rr_seq_ch", 32'(out_ch), 32'd0);
`else
            chk("rr_seq_ch", 32'(out_ch), 32'((i + 2) % 4));
`endif
            chk("rr_seq_valid", 32'(out_valid), 32'd1);
        end
        apply(4'b0000, 32'h0, 1'b1);
        apply(4'b0000, 32'h0, 1'b1);
        chk("drain_sb_empty", 32'(q.size()), 32'd0);

        // Three-channel wrap
        d3 = 24'hC3B2A1;
        v3 = 3'b010;
        @(posedge clk);
        #1;
        chk("n3_first_ch", 32'(och3), 32'd1);
        chk("n3_first_data", 32'(od3), 32'hB2);
        v3 = 3'b011;
        @(posedge clk);
        #1;
        chk("n3_wrap_ch", 32'(och3), 32'd0);
        chk("n3_wrap_data", 32'(od3), 32'hA1);
        @(posedge clk);
        #1;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        chk("n3_after_ch", 32'(och3), 32'd0);
`else
        chk("n3_after_ch", 32'(och3), 32'd1);
`endif
        chk("n3_valid", 32'(ov3), 32'd1);
        v3 = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
